sid_i2s: RTL and testbench
==========================

SID_I2S -- requirements
Module: sid_i2s

Interface
REQ-001 Parameter: BCK_DIV, default 4, clk cycles per BCK half-period; legal range 2..16.
REQ-002 clk  input  1  system clock; the only clock; all outputs registered on its rising edge.
REQ-003 res  input  1  reset, synchronous, active-high.
REQ-004 audio_i  input  sid::audio_t (48)  {left s24, right s24} from sid_api audio_o; sampled only at frame start.
REQ-005 i2s_bck  output  1  bit clock, period 2*BCK_DIV clk.
REQ-006 i2s_lrck  output  1  word select; 0 = left, 1 = right.
REQ-007 i2s_dout  output  1  serial data, MSB first.
REQ-008 frame_o  output  1  one-clk pulse at each frame start, when audio_i is latched.
REQ-009 i2s_din  input  1  serial ADC data; present only with I2S_EXT_IN_EN.
REQ-010 ext_audio_o  output  sid::audio_t (48)  received {left, right}, feeding sid_api audio_i; present only with I2S_EXT_IN_EN.
REQ-011 ext_valid  output  1  one-clk pulse when ext_audio_o updates; present only with I2S_EXT_IN_EN.

Function
REQ-012 div_cnt counts 0..BCK_DIV-1 and wraps; i2s_bck toggles on the clk edge where div_cnt == BCK_DIV-1.
REQ-013 "Fall event" is a toggle with i2s_bck == 1; "rise event" is a toggle with i2s_bck == 0.
REQ-014 6-bit bit_cnt advances by 1 on each fall event and wraps 63 -> 0; one frame is 64 BCK, i.e. 128*BCK_DIV clk.
REQ-015 On the fall event taking bit_cnt 63 -> 0: audio_i loads into a 48-bit shift register, frame_o = 1 for that clk only, and i2s_lrck = 0.
REQ-016 On the fall event taking bit_cnt to 32: i2s_lrck = 1. This puts LRCK one BCK ahead of each MSB (Philips I2S).
REQ-017 i2s_dout after a fall event to bit_cnt k:
- k = 1..24: left[24-k]
- k = 33..56: right[56-k]
- all other k: 0
REQ-018 i2s_dout, i2s_lrck and frame_o change only on fall events. Data is stable across every rise event.
REQ-019 A change of audio_i mid-frame does not affect the frame in progress. It is transmitted in the next frame only if still present at the next latch.
REQ-020 Two's-complement bits pass unmodified; no rounding, saturation or sign handling.

Reset
REQ-021 While res = 1, at every clk edge:
- div_cnt = 0, bit_cnt = 63
- i2s_bck = 0, i2s_lrck = 1, i2s_dout = 0, frame_o = 0
- shift register = 0
- ext_audio_o = 0, ext_valid = 0 (when compiled in)
REQ-022 res has priority over all other events, including a simultaneous fall event or a frame latch.
REQ-023 After res deasserts, the first frame_o pulse occurs on the (2*BCK_DIV)-th rising clk edge with res = 0.
REQ-024 res asserted mid-frame aborts the frame. Transmission restarts at a fresh frame with no partial-word carry-over.

Configuration
REQ-025 Macro I2S_EXT_IN_EN defined: the receive path, i2s_din, ext_audio_o and ext_valid are compiled in.
REQ-026 Receive capture: on the rise event while bit_cnt = k, i2s_din shifts into the left receive register (k = 1..24) or the right receive register (k = 33..56), MSB first.
REQ-027 Receive update: on the rise event with bit_cnt = 56, ext_audio_o = {left, right including this bit} and ext_valid = 1 for one clk. ext_audio_o holds until the next update.
REQ-028 Macro I2S_EXT_IN_EN undefined: those three ports and all receive logic are absent; the transmit behaviour is identical.

Verification
REQ-029 BCK_DIV=4, res released -> i2s_bck period 8 clk; i2s_lrck period 512 clk with 50% duty; frame_o first at clk 8, then every 512 clk.
REQ-030 audio_i = {24'h800001, 24'h7FFFFE} -> left slot bits 1..24 = 1,0x22,1; right slot bits 33..56 = 0,1x22,0; every other bit 0.
REQ-031 audio_i switched from 0 to {24'hFFFFFF, 24'hFFFFFF} 100 clk after frame_o -> current frame all-zero; next frame has 48 ones.
REQ-032 res pulsed for 1 clk at bit_cnt = 40 -> next edge outputs match reset values; next frame_o exactly 2*BCK_DIV clk after res drops.
REQ-033 I2S_EXT_IN_EN, i2s_dout looped to i2s_din, audio_i = {24'h123456, 24'hABCDEF} -> ext_audio_o = {24'h123456, 24'hABCDEF}; ext_valid once per frame, 56 BCK after frame_o.
REQ-034 I2S_EXT_IN_EN undefined -> module elaborates without i2s_din, ext_audio_o and ext_valid; REQ-029 and REQ-030 still pass.

Source files
------------

// File: rtl/sid_i2s.sv
// I2S transmitter for the SID audio path: 64-BCK Philips frames, 24-bit slots, BCK = clk / (2*BCK_DIV).
// Define I2S_EXT_IN_EN to add the loop-in receiver (i2s_din -> ext_audio_o / ext_valid).
module sid_i2s #(
    parameter int BCK_DIV = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic [47:0] audio_i,
`ifdef I2S_EXT_IN_EN
    input  logic        i2s_din,
    output logic [47:0] ext_audio_o,
    output logic        ext_valid,
`endif
    output logic        i2s_bck,
    output logic        i2s_lrck,
    output logic        i2s_dout,
    output logic        frame_o
);
    localparam int DW = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [5:0]    bit_cnt;
    logic [5:0]    bit_nxt;
    logic [47:0]   shreg;
    logic          toggle;
    logic          fall_ev;

    assign toggle  = (div_cnt == DW'(BCK_DIV - 1));
    assign fall_ev = toggle & i2s_bck;
    assign bit_nxt = bit_cnt + 6'd1;

    function automatic logic in_slot(input logic [5:0] k);
        return ((k >= 6'd1) && (k <= 6'd24)) || ((k >= 6'd33) && (k <= 6'd56));
    endfunction

    always_ff @(posedge clk) begin
        if (res) begin
            div_cnt  <= '0;
            bit_cnt  <= 6'd63;
            i2s_bck  <= 1'b0;
            i2s_lrck <= 1'b1;
            i2s_dout <= 1'b0;
            frame_o  <= 1'b0;
            shreg    <= '0;
        end else begin
            frame_o <= 1'b0;
            div_cnt <= toggle ? '0 : div_cnt + DW'(1);
            if (toggle)
                i2s_bck <= ~i2s_bck;
            // All data, word select and framing move on the BCK falling edge only.
            if (fall_ev) begin
                bit_cnt <= bit_nxt;
                if (bit_nxt == 6'd0) begin
                    shreg    <= audio_i;
                    frame_o  <= 1'b1;
                    i2s_lrck <= 1'b0;
                    i2s_dout <= 1'b0;
                end else begin
                    if (bit_nxt == 6'd32)
                        i2s_lrck <= 1'b1;
                    if (in_slot(bit_nxt)) begin
                        i2s_dout <= shreg[47];
                        shreg    <= {shreg[46:0], 1'b0};
                    end else begin
                        i2s_dout <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef I2S_EXT_IN_EN
    logic        rise_ev;
    logic [23:0] rx_left;
    logic [23:0] rx_right;

    assign rise_ev = toggle & ~i2s_bck;

    // Capture on the BCK rising edge, mid-bit, while bit_cnt still names the bit on the wire.
    always_ff @(posedge clk) begin
        if (res) begin
            rx_left     <= '0;
            rx_right    <= '0;
            ext_audio_o <= '0;
            ext_valid   <= 1'b0;
        end else begin
            ext_valid <= 1'b0;
            if (rise_ev) begin
                if ((bit_cnt >= 6'd1) && (bit_cnt <= 6'd24))
                    rx_left <= {rx_left[22:0], i2s_din};
                if ((bit_cnt >= 6'd33) && (bit_cnt <= 6'd56))
                    rx_right <= {rx_right[22:0], i2s_din};
                if (bit_cnt == 6'd56) begin
                    ext_audio_o <= {rx_left, rx_right[22:0], i2s_din};
                    ext_valid   <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sid_i2s.sv
// Scoreboard bench for sid_i2s: random audio per frame, frames rebuilt from the slot rules and compared bit by bit.
// With I2S_EXT_IN_EN, dout is looped to din and the received words are checked too.
module tb_sid_i2s;
    localparam int D     = 4;
    localparam int FRAME = 128 * D;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [47:0] audio_i = '0;
    logic        i2s_bck, i2s_lrck, i2s_dout, frame_o;
`ifdef I2S_EXT_IN_EN
    logic        i2s_din;
    logic [47:0] ext_audio_o;
    logic        ext_valid;
    assign i2s_din = i2s_dout;
`endif

    sid_i2s #(.BCK_DIV(D)) dut (
        .clk        (clk),
        .res        (res),
        .audio_i    (audio_i),
`ifdef I2S_EXT_IN_EN
        .i2s_din    (i2s_din),
        .ext_audio_o(ext_audio_o),
        .ext_valid  (ext_valid),
`endif
        .i2s_bck    (i2s_bck),
        .i2s_lrck   (i2s_lrck),
        .i2s_dout   (i2s_dout),
        .frame_o    (frame_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] bits;
        logic [47:0] audio;
    } exp_t;

    exp_t   sb_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     n_push = 0;
    int     frames_done = 0;
    int     ext_seen = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference frame: bit k on the wire after the k-th BCK fall of the frame.
    function automatic logic [63:0] frame_bits(input logic [47:0] a);
        logic [23:0] l;
        logic [23:0] r;
        logic [63:0] f;
        l = a[47:24];
        r = a[23:0];
        f = '0;
        for (int i = 1; i <= 24; i++) f[i] = l[24 - i];
        for (int i = 33; i <= 56; i++) f[i] = r[56 - i];
        return f;
    endfunction

    function automatic logic [47:0] rand48();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[47:0];
    endfunction

    task automatic push(input logic [47:0] a);
        exp_t e;
        e.bits  = frame_bits(a);
        e.audio = a;
        sb_q.push_back(e);
        n_push++;
    endtask

    // Monitor: samples on the falling clk edge, reconstructs BCK events from the outputs.
    logic        prev_bck = 1'b0;
    bit          in_frame = 1'b0;
    int          mon_k = 0;
    exp_t        cur;
    logic [63:0] got_d, got_l;
    longint      last_fall = -1;
    longint      last_frame = -1;

    always @(negedge clk) begin
        if (res) begin
            prev_bck   = 1'b0;
            in_frame   = 1'b0;
            last_fall  = -1;
            last_frame = -1;
        end else begin
            if (prev_bck && !i2s_bck) begin
                if (last_fall >= 0) check("bck_period", 64'(cyc - last_fall), 64'(2 * D));
                last_fall = cyc;
                if (frame_o) begin
                    if (last_frame >= 0) check("frame_period", 64'(cyc - last_frame), 64'(FRAME));
                    last_frame = cyc;
                    if (sb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL frame_start: frame_o seen, expected no frame (queue empty)");
                        in_frame = 1'b0;
                    end else begin
                        cur      = sb_q.pop_front();
                        in_frame = 1'b1;
                        mon_k    = 0;
                        got_d    = '0;
                        got_l    = '0;
                    end
                end else if (in_frame) begin
                    mon_k++;
                end
                if (in_frame) begin
                    got_d[mon_k] = i2s_dout;
                    got_l[mon_k] = i2s_lrck;
                    if (mon_k == 63) begin
                        check("dout_frame", got_d, cur.bits);
                        check("lrck_frame", got_l, 64'hFFFF_FFFF_0000_0000);
                        frames_done++;
                        in_frame = 1'b0;
                    end
                end
            end else begin
                if (frame_o) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL frame_o_timing: frame_o=1 at cycle %0d, expected only on a BCK fall", cyc);
                end
                if (!prev_bck && i2s_bck && in_frame) begin
                    check("rise_dout_stable", 64'(i2s_dout), 64'(got_d[mon_k]));
                    check("rise_lrck_stable", 64'(i2s_lrck), 64'(got_l[mon_k]));
                end
            end
`ifdef I2S_EXT_IN_EN
            if (ext_valid) begin
                check("ext_audio", 64'(ext_audio_o), 64'(cur.audio));
                check("ext_slot", 64'(mon_k), 64'd56);
                ext_seen++;
            end
`endif
            prev_bck = i2s_bck;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_bck"},   64'(i2s_bck),  64'd0);
        check({tag, "_lrck"},  64'(i2s_lrck), 64'd1);
        check({tag, "_dout"},  64'(i2s_dout), 64'd0);
        check({tag, "_frame"}, 64'(frame_o),  64'd0);
`ifdef I2S_EXT_IN_EN
        check({tag, "_ext_audio"}, 64'(ext_audio_o), 64'd0);
        check({tag, "_ext_valid"}, 64'(ext_valid),   64'd0);
`endif
    endtask

    task automatic wait_frame(input string tag, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!frame_o && n < 2 * FRAME);
        if (!frame_o) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no frame_o within %0d clk, expected one", tag, n);
        end
    endtask

    task automatic wait_falls(input int cnt);
        int   seen;
        int   guard;
        logic pb;
        seen  = 0;
        guard = 0;
        pb    = i2s_bck;
        while (seen < cnt && guard < 4 * D * cnt + 8) begin
            @(posedge clk);
            #1;
            guard++;
            if (pb && !i2s_bck) seen++;
            pb = i2s_bck;
        end
        if (seen < cnt) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_falls: saw %0d BCK falls, expected %0d", seen, cnt);
        end
    endtask

    // Called just after a frame_o: changes audio_i mid-frame (optionally via a junk value first).
    task automatic next_value(input int offset, input logic [47:0] val, input bit junk);
        int n;
        for (int i = 1; i <= offset; i++) begin
            @(posedge clk);
            #1;
            if (junk && i == offset / 2) audio_i = rand48();
        end
        audio_i = val;
        push(val);
        wait_frame("next_frame", n);
        check("frame_spacing", 64'(n), 64'(FRAME - offset));
    endtask

    initial begin
        int          n;
        logic [47:0] a;
        res     = 1'b1;
        audio_i = {24'h800001, 24'h7FFFFE};
        push(audio_i);
        repeat (3) @(posedge clk);
        #1;
        check_reset("init");
        res = 1'b0;
        wait_frame("first_frame", n);
        check("first_frame_latency", 64'(n), 64'(2 * D));

        next_value(100, 48'h0, 1'b0);
        next_value(100, {24'hFFFFFF, 24'hFFFFFF}, 1'b0);
        next_value(FRAME - 1, rand48(), 1'b1);
        for (int i = 0; i < 7; i++)
            next_value(int'($urandom_range(FRAME - 1, 1)), rand48(), $urandom_range(1, 0) == 1);

        // One-clk reset at bit 40 of the current frame aborts it.
        wait_falls(40);
        res = 1'b1;
        @(posedge clk);
        #1;
        check_reset("mid_reset");
        res = 1'b0;
        a = rand48();
        audio_i = a;
        push(a);
        wait_frame("post_reset", n);
        check("post_reset_latency", 64'(n), 64'(2 * D));
        push(a);
        wait_frame("post_reset_next", n);
        check("post_reset_spacing", 64'(n), 64'(FRAME));
        repeat (127 * D) @(posedge clk);
        #1;

        check("frames_done", 64'(frames_done), 64'(n_push - 1));
        check("queue_empty", 64'(sb_q.size()), 64'd0);
`ifdef I2S_EXT_IN_EN
        check("ext_count", 64'(ext_seen), 64'(frames_done));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
